// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
//
// Shared definitions for the single-port SRAM request controller.
//   - SRAM_DATA_WIDTH / SRAM_ADDR_WIDTH : default geometry of the 32x128 macro
//   - RD_LAT                            : cycles from request accept to the
//                                         edge that captures read data
//   - ctrl_state_e                      : controller FSM states
//   - init_last_idx()                   : terminal index of a clear walk
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

  localparam int SRAM_DATA_WIDTH = 32;
  localparam int SRAM_ADDR_WIDTH = 7;

  // Accept edge N -> macro samples at N+1 -> dout0 captured at N+2.
  localparam int RD_LAT = 2;

  typedef enum logic {
    S_INIT = 1'b0,  // clear walk in progress, client blocked
    S_RUN  = 1'b1   // client traffic
  } ctrl_state_e;

  // Last address written by a clear of a depth-word array.
  function automatic int init_last_idx(input int depth);
    return depth - 1;
  endfunction

endpackage : sram_ctrl_pkg

// File: rtl/sram_ctrl_1rw_if.sv
// -----------------------------------------------------------------------------
// sram_ctrl_1rw_if
//
// Client-side request/response bundle of sram_ctrl_1rw.
//   req_valid  : client has a request this cycle
//   req_ready  : controller accepts a request this cycle (combinational)
//   req_we     : 1 = write, 0 = read
//   req_addr   : word address
//   req_wdata  : write data
//   rsp_valid  : one-cycle strobe, rsp_rdata carries read data
//   rsp_rdata  : read data
//
// master : the client (drives the request, sees ready/response)
// slave  : the controller
// -----------------------------------------------------------------------------
interface sram_ctrl_1rw_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata
  );

endinterface : sram_ctrl_1rw_if

// File: rtl/sram_ctrl_1rw_init_seq.sv
// -----------------------------------------------------------------------------
// sram_init_seq
//
// Clear-walk address generator. While enable is high it presents one address
// per cycle, 0 .. RAM_DEPTH-1, then stops. restart rewinds the walk to 0.
//
// Ports:
//   clk0, rst0_n : clock, synchronous active-low reset (rewinds to 0)
//   restart      : rewind the counter to 0 on the next edge
//   enable       : walk is allowed to advance (controller is in S_INIT)
//   active       : a clear write should be issued this cycle
//   addr         : address of that clear write
//   done         : this cycle issues the final clear write
// -----------------------------------------------------------------------------
module sram_init_seq
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  restart,
  input  logic                  enable,
  output logic                  active,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  done
);

  // One extra bit so the counter parks at RAM_DEPTH after the last write
  // instead of wrapping back onto address 0.
  localparam int              CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(init_last_idx(RAM_DEPTH));

  logic [CNT_W-1:0] icnt_q;
  logic [CNT_W-1:0] icnt_d;
  logic             in_range;

  assign in_range = (icnt_q <= LAST);

  always_comb begin
    icnt_d = icnt_q;
    if (restart) begin
      icnt_d = '0;
    end else if (enable && in_range) begin
      icnt_d = icnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk0) begin
    if (!rst0_n) begin
      icnt_q <= '0;
    end else begin
      icnt_q <= icnt_d;
    end
  end

  assign active = enable && in_range;
  assign addr   = icnt_q[ADDR_WIDTH-1:0];
  assign done   = active && (icnt_q == LAST);

endmodule : sram_init_seq

// File: rtl/sram_ctrl_1rw.sv
// -----------------------------------------------------------------------------
// sram_ctrl_1rw
//
// Request-side controller for a single-port (1rw) SRAM macro. Turns a
// valid/ready request stream into registered csb0/web0/addr0/din0 pin
// activity and returns read data on a one-cycle rsp_valid strobe, RD_LAT
// edges after acceptance. After reset, and on init_req, the whole array is
// overwritten with INIT_VALUE before client traffic is admitted again.
//
// Ports:
//   clk0       : clock, rising edge
//   rst0_n     : synchronous active-low reset
//   bus        : client request/response bundle (slave side)
//   init_req   : start a full-array clear (ignored while one is running)
//   init_done  : high once a clear has completed, low while one runs
//   csb0/web0  : macro chip select / write enable, both active low
//   addr0/din0 : macro address / write data
//   dout0      : macro read data, stable one edge after the read is sampled
// -----------------------------------------------------------------------------
module sram_ctrl_1rw
  import sram_ctrl_pkg::*;
#(
  parameter int                   DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int                   ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int                   RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  sram_ctrl_1rw_if.slave        bus,
  input  logic                  init_req,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  ctrl_state_e state_q, state_d;
  logic        init_done_q, init_done_d;

  logic                  csb0_q, csb0_d;
  logic                  web0_q, web0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;

  // Bit i set: a read accepted i+1 edges ago is still in flight.
  logic [RD_LAT-1:0]     rd_tag_q, rd_tag_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                  req_ready;
  logic                  accept;
  logic                  init_start;

  logic                  seq_active;
  logic [ADDR_WIDTH-1:0] seq_addr;
  logic                  seq_done;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // Ready drops in the init_req cycle itself so a request cannot slip in
  // alongside the clear; rst0_n is folded in so ready is low during reset.
  assign req_ready  = (state_q == S_RUN) && !init_req && rst0_n;
  assign accept     = bus.req_valid && req_ready;
  assign init_start = (state_q == S_RUN) && init_req;

  assign bus.req_ready = req_ready;

  // ---------------------------------------------------------------------------
  // Clear walk
  // ---------------------------------------------------------------------------
  sram_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_DEPTH  (RAM_DEPTH)
  ) u_init_seq (
    .clk0    (clk0),
    .rst0_n  (rst0_n),
    .restart (init_start),
    .enable  (state_q == S_INIT),
    .active  (seq_active),
    .addr    (seq_addr),
    .done    (seq_done)
  );

  // ---------------------------------------------------------------------------
  // FSM: next state and init_done
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
    unique case (state_q)
      S_INIT: begin
        // Leave as the last clear write is registered onto the pins, so
        // init_done rises on the same edge that presents that write.
        if (seq_done) begin
          state_d     = S_RUN;
          init_done_d = 1'b1;
        end
      end
      S_RUN: begin
        if (init_req) begin
          state_d     = S_INIT;
          init_done_d = 1'b0;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Macro pin next values: clear walk has priority over the client path
  // ---------------------------------------------------------------------------
  always_comb begin
    csb0_d  = 1'b1;
    web0_d  = 1'b1;
    addr0_d = addr0_q;
    din0_d  = din0_q;
    if (seq_active) begin
      csb0_d  = 1'b0;
      web0_d  = 1'b0;
      addr0_d = seq_addr;
      din0_d  = INIT_VALUE;
    end else if (accept) begin
      csb0_d  = 1'b0;
      web0_d  = ~bus.req_we;
      addr0_d = bus.req_addr;
      // Reads leave din0 alone to avoid needless toggling on the macro bus.
      if (bus.req_we) begin
        din0_d = bus.req_wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-tag pipeline and response register
  // ---------------------------------------------------------------------------
  // Tags are not cleared by init_req: reads already on the pins complete
  // normally while the clear starts behind them.
  always_comb begin
    rd_tag_d    = '0;
    rd_tag_d[0] = accept && !bus.req_we;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_tag_d[i] = rd_tag_q[i-1];
    end
  end

  always_comb begin
    rsp_valid_d = rd_tag_q[RD_LAT-1];
    rsp_rdata_d = rsp_rdata_q;
    if (rd_tag_q[RD_LAT-1]) begin
      rsp_rdata_d = dout0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk0) begin
    if (!rst0_n) begin
      state_q     <= S_INIT;
      init_done_q <= 1'b0;
      csb0_q      <= 1'b1;
      web0_q      <= 1'b1;
      addr0_q     <= '0;
      din0_q      <= '0;
      rd_tag_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      csb0_q      <= csb0_d;
      web0_q      <= web0_d;
      addr0_q     <= addr0_d;
      din0_q      <= din0_d;
      rd_tag_q    <= rd_tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign init_done     = init_done_q;
  assign csb0          = csb0_q;
  assign web0          = web0_q;
  assign addr0         = addr0_q;
  assign din0          = din0_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule : sram_ctrl_1rw

// File: tb/tb_sram_ctrl_1rw.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl_1rw
//
// Bench for sram_ctrl_1rw with a behavioural SRAM macro attached to the pins.
// The reference model is an array of expected word contents plus a queue of
// expected responses (cycle, data); observed strobes are logged per cycle.
// -----------------------------------------------------------------------------
module tb_sram_ctrl_1rw;

  localparam int          DW     = 32;
  localparam int          AW     = 7;
  localparam int          DEPTH  = 1 << AW;
  localparam logic [31:0] INIT_V = 32'h0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic          clk0 = 1'b0;
  logic          rst0_n;
  logic          init_req;
  logic          init_done;
  logic          csb0;
  logic          web0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0;

  sram_ctrl_1rw_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sram_ctrl_1rw #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RAM_DEPTH  (DEPTH),
    .INIT_VALUE (INIT_V)
  ) dut (
    .clk0      (clk0),
    .rst0_n    (rst0_n),
    .bus       (bus.slave),
    .init_req  (init_req),
    .init_done (init_done),
    .csb0      (csb0),
    .web0      (web0),
    .addr0     (addr0),
    .din0      (din0),
    .dout0     (dout0)
  );

  always #5 clk0 = ~clk0;

  // Behavioural 1rw macro: samples pins on the rising edge, read data
  // appears after that edge.
  logic [DW-1:0] macro_mem [DEPTH];
  always @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) macro_mem[addr0] <= din0;
      else       dout0 <= macro_mem[addr0];
    end
  end

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [31:0] ref_mem [DEPTH];
  rsp_t        exp_q[$];
  rsp_t        obs_q[$];

  // Advance one clock; sample 1 time unit after the edge and log strobes.
  task automatic tick();
    rsp_t r;
    @(posedge clk0);
    #1;
    cyc++;
    if (bus.rsp_valid !== 1'b0) begin
      r.due  = cyc;
      r.data = bus.rsp_rdata;
      obs_q.push_back(r);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT_V;
  endtask

  // Drive one cycle of inputs; report whether the DUT accepted a request and
  // update the reference model accordingly. Data expected 2 edges after the
  // accept edge (cyc+1), i.e. visible at sample cyc+3.
  task automatic issue(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic ini, output logic acc);
    rsp_t r;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    init_req      = ini;
    #1;
    acc = v && (bus.req_ready === 1'b1);
    if (acc) begin
      if (we) begin
        ref_mem[a] = d;
        $display("TXN cyc=%0d WR addr=%0d data=%h", cyc, a, d);
      end else begin
        r.due  = cyc + 3;
        r.data = ref_mem[a];
        exp_q.push_back(r);
        $display("TXN cyc=%0d RD addr=%0d expect=%h", cyc, a, r.data);
      end
    end
    if (ini) model_clear();
  endtask

  task automatic idle();
    logic acc;
    issue(1'b0, 1'b0, '0, '0, 1'b0, acc);
  endtask

  // Walk n cycles of a clear, checking pins, init_done and ready each cycle.
  // pulse_at: cycle index at which an init_req is raised (must be ignored).
  task automatic walk_clear(input int n, input int pulse_at, input string name);
    logic exp_rdy;
    for (int k = 0; k < n; k++) begin
      tick();
      checks++;
      if (csb0 !== 1'b0 || web0 !== 1'b0 || din0 !== INIT_V || addr0 !== AW'(k)) begin
        failures++;
        $display("FAIL %s_pins k=%0d got csb0=%b web0=%b addr0=%0d din0=%h want 0 0 %0d %h",
                 name, k, csb0, web0, addr0, din0, k, INIT_V);
      end
      checks++;
      if (init_done !== (k == DEPTH - 1)) begin
        failures++;
        $display("FAIL %s_init_done k=%0d got %b want %b", name, k, init_done, k == DEPTH - 1);
      end
      bus.req_valid = 1'b0;
      init_req      = (k == pulse_at);
      #1;
      exp_rdy = (k == DEPTH - 1) && (k != pulse_at);
      checks++;
      if (bus.req_ready !== exp_rdy) begin
        failures++;
        $display("FAIL %s_ready k=%0d got %b want %b", name, k, bus.req_ready, exp_rdy);
      end
    end
    init_req = 1'b0;
  endtask

  // Idle n cycles, then compare the observed strobes against the model.
  task automatic drain_and_score(input int n, input string name);
    idle();
    repeat (n) tick();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_rsp_count got %0d want %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].due != exp_q[i].due || obs_q[i].data !== exp_q[i].data) begin
        failures++;
        $display("FAIL %s_rsp[%0d] got cyc=%0d data=%h want cyc=%0d data=%h",
                 name, i, obs_q[i].due, obs_q[i].data, exp_q[i].due, exp_q[i].data);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    logic acc;
    rst0_n = 1'b0;
    idle();
    tick();
    tick();
    checks++;
    if (csb0 !== 1'b1 || web0 !== 1'b1 || addr0 !== '0 || din0 !== '0) begin
      failures++;
      $display("FAIL reset_pins got csb0=%b web0=%b addr0=%0d din0=%h want 1 1 0 0",
               csb0, web0, addr0, din0);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== '0 || init_done !== 1'b0 || bus.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_outs got rsp_valid=%b rsp_rdata=%h init_done=%b req_ready=%b want 0 0 0 0",
               bus.rsp_valid, bus.rsp_rdata, init_done, bus.req_ready);
    end
    obs_q.delete();
    exp_q.delete();
    rst0_n = 1'b1;
    model_clear();
    walk_clear(DEPTH, -1, "reset_clear");
    issue(1'b1, 1'b0, AW'(127), '0, 1'b0, acc);
    checks++;
    if (acc !== 1'b1) begin
      failures++;
      $display("FAIL reset_rd127_accept got %b want 1", acc);
    end
    tick();
    drain_and_score(4, "reset_rd127");
  endtask

  task automatic test_write_read();
    logic acc;
    issue(1'b1, 1'b1, AW'(10), 32'hFACECAFE, 1'b0, acc);
    tick();
    issue(1'b1, 1'b0, AW'(10), '0, 1'b0, acc);
    tick();
    drain_and_score(4, "raw10");
  endtask

  task automatic test_back_to_back();
    logic acc;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b1, AW'(i), 32'h11111111 * (i + 1), 1'b0, acc);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, AW'(i), '0, 1'b0, acc);
      checks++;
      if (acc !== 1'b1) begin
        failures++;
        $display("FAIL b2b_accept[%0d] got %b want 1", i, acc);
      end
      tick();
    end
    drain_and_score(4, "b2b");
  endtask

  task automatic test_random();
    logic v, we, acc;
    for (int n = 0; n < 300; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1) == 1;
      issue(v, we, AW'($urandom_range(0, 15)), $urandom, 1'b0, acc);
      checks++;
      if (acc !== v) begin
        failures++;
        $display("FAIL rand_accept n=%0d got %b want %b", n, acc, v);
      end
      tick();
    end
    drain_and_score(4, "rand");
  endtask

  task automatic test_init_req();
    logic acc;
    issue(1'b1, 1'b1, AW'(5), 32'hDEADBEEF, 1'b0, acc);
    tick();
    issue(1'b1, 1'b0, AW'(1), '0, 1'b0, acc);
    tick();
    issue(1'b1, 1'b0, AW'(2), '0, 1'b0, acc);
    tick();
    issue(1'b1, 1'b1, AW'(5), 32'hFACECAFE, 1'b1, acc);
    checks++;
    if (bus.req_ready !== 1'b0 || acc !== 1'b0) begin
      failures++;
      $display("FAIL initreq_ready got ready=%b accept=%b want 0 0", bus.req_ready, acc);
    end
    tick();
    checks++;
    if (csb0 !== 1'b1 || init_done !== 1'b0) begin
      failures++;
      $display("FAIL initreq_gap got csb0=%b init_done=%b want 1 0", csb0, init_done);
    end
    idle();
    walk_clear(DEPTH, 50, "initreq_clear");
    drain_and_score(2, "initreq_inflight");
    issue(1'b1, 1'b0, AW'(5), '0, 1'b0, acc);
    tick();
    drain_and_score(4, "initreq_rd5");
  endtask

  task automatic test_reset_mid_clear();
    rst0_n = 1'b0;
    idle();
    tick();
    rst0_n = 1'b1;
    model_clear();
    walk_clear(40, -1, "midclr_pre");
    rst0_n = 1'b0;
    tick();
    checks++;
    if (csb0 !== 1'b1 || addr0 !== '0 || init_done !== 1'b0) begin
      failures++;
      $display("FAIL midclr_reset got csb0=%b addr0=%0d init_done=%b want 1 0 0", csb0, addr0, init_done);
    end
    rst0_n = 1'b1;
    walk_clear(DEPTH, -1, "midclr_restart");
    drain_and_score(2, "midclr");
  endtask

  task automatic test_reset_mid_read();
    logic acc;
    issue(1'b1, 1'b1, AW'(20), 32'h0BADF00D, 1'b0, acc);
    tick();
    issue(1'b1, 1'b0, AW'(20), '0, 1'b0, acc);
    checks++;
    if (acc !== 1'b1) begin
      failures++;
      $display("FAIL midrd_accept got %b want 1", acc);
    end
    tick();
    rst0_n = 1'b0;
    idle();
    tick();
    rst0_n = 1'b1;
    exp_q.delete();
    model_clear();
    walk_clear(DEPTH, -1, "midrd_clear");
    drain_and_score(3, "midrd_lost");
  endtask

  initial begin
    rst0_n        = 1'b0;
    init_req      = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_random();
    test_init_req();
    test_reset_mid_clear();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_sram_ctrl_1rw

// File: doc/sram_ctrl_1rw.md
# sram_ctrl_1rw

Request-side controller for the 32x128 single-port (1rw) SRAM macro. Converts a valid/ready request stream into the macro's `csb0`/`web0`/`addr0`/`din0` pin protocol and returns read data on a response strobe. After reset it clears the array to a fill value, and it can re-clear it on command. It sits between client logic and the SRAM macro and is the only driver of the macro pins.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width.
- `ADDR_WIDTH`, 7: address width.
- `RAM_DEPTH`, `1 << ADDR_WIDTH`: number of words.
- `INIT_VALUE`, `32'h0`: fill word written during init.

Ports (one clock, `clk0`; reset `rst0_n` is synchronous and active-low):
- `clk0`  in  1  clock; all logic on the rising edge.
- `rst0_n`  in  1  synchronous active-low reset.
- `req_valid`  in  1  client request present.
- `req_ready`  out  1  controller accepts a request this cycle.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  word address.
- `req_wdata`  in  DATA_WIDTH  write data.
- `rsp_valid`  out  1  one-cycle strobe; `rsp_rdata` is valid.
- `rsp_rdata`  out  DATA_WIDTH  read data.
- `init_req`  in  1  start a full-array clear.
- `init_done`  out  1  high once a clear has completed; low while a clear runs.
- `csb0`  out  1  macro chip select, active low.
- `web0`  out  1  macro write enable, active low.
- `addr0`  out  ADDR_WIDTH  macro address.
- `din0`  out  DATA_WIDTH  macro write data.
- `dout0`  in  DATA_WIDTH  macro read data.

## Operation
- FSM states:
  - `S_INIT`: clear counter `icnt` walks the array.
  - `S_RUN`: client traffic.
- Transitions:
  - Reset forces `S_INIT` with `icnt=0`.
  - `S_INIT` goes to `S_RUN` after issuing the write to `RAM_DEPTH-1`.
  - `S_RUN` goes to `S_INIT` (with `icnt=0`) on `init_req`.
- Behaviour in `S_INIT`:
  - Each cycle issues a write with `addr0=icnt` and `din0=INIT_VALUE`, then increments `icnt`.
  - `icnt` is ADDR_WIDTH+1 bits wide, so the terminal value is detected without wrap.
- Handshake:
  - `req_ready = (state==S_RUN) && !init_req && rst0_n`. This is combinational and does not depend on `req_valid`.
  - A request is accepted when `req_valid && req_ready`.
- On an accepted request the macro pins register as follows:
  - `csb0=0`.
  - `web0=~req_we`.
  - `addr0=req_addr`.
  - `din0=req_wdata` on a write. On a read `din0` holds its previous value.
- Idle cycles (in `S_RUN` with no accept): `csb0=1`, `web0=1`; `addr0` and `din0` hold.
- Responses:
  - Writes produce no response.
  - Reads produce exactly one `rsp_valid` strobe each, in issue order.
- Read tracking: a 2-stage read-tag shift register tracks reads in flight.
- `init_req` while reads are in flight: the in-flight reads still return their data. Init writes start the cycle after `init_req`.
- `init_req` while already in `S_INIT` is ignored; the current clear is not restarted.
- There is no response backpressure. The client must always be able to take `rsp_valid`.

## Timing
- Reset values:
  - `csb0=1`, `web0=1`, `addr0=0`, `din0=0`.
  - `rsp_valid=0`, `rsp_rdata=0`.
  - `init_done=0`, `req_ready=0`.
- Macro model: the macro samples its pins at rising edge E. It drives `dout0` for a read after E, and the value is stable by E+1.
- Request accepted at edge N:
  - Pins are valid after N.
  - The macro acts at edge N+1.
  - For a read, the controller captures `dout0` into `rsp_rdata` at edge N+2, and `rsp_valid` is high for the cycle following N+2.
  - Read latency is 2 cycles from acceptance.
- Throughput is one request per cycle, any read/write mix, back-to-back.
- Read after write to the same address in the next cycle returns the new data, because the macro serializes accesses.
- Clear duration is `RAM_DEPTH` cycles (128 by default):
  - After reset deasserts, the first clear write's pins are valid after the first edge.
  - `init_done` rises at the same edge at which the last clear write is presented.
  - `req_ready` rises in the cycle after that edge.
- Reset mid-clear or mid-read:
  - Flushes the read pipeline; no `rsp_valid` is produced for lost reads.
  - Restarts the clear from address 0.

## Structure
- Package `sram_ctrl_pkg` holds:
  - the state enum `S_INIT`/`S_RUN`;
  - the default `DATA_WIDTH`/`ADDR_WIDTH` localparams;
  - the read-latency constant `RD_LAT=2`.
- Sub-module `sram_init_seq`: the clear counter and its terminal detect, with outputs `active`, `addr`, `done`. The top level muxes its outputs onto the macro pins ahead of the client path.
- The read-tag pipeline and the response register stay in the top level.

## Test plan
- Reset release: count cycles while `csb0=0`, `web0=0`, `din0=0`, and `addr0` steps 0..127 → `init_done` goes high after 128 cycles and `req_ready` rises the following cycle; then read addr 127 → `rsp_rdata=32'h0` exactly 2 cycles after accept.
- Write addr 10 with `32'hFACECAFE`, then read addr 10 the next cycle → a single `rsp_valid` with `rsp_rdata=32'hFACECAFE`, 2 cycles after the read accept.
- Reads to addrs 0..3 on consecutive cycles after prior writes of `32'h11111111`..`32'h44444444` → `rsp_valid` high for 4 consecutive cycles, data in order.
- `init_req` asserted in the same cycle as `req_valid` (a write to addr 5) with 2 reads in flight:
  - `req_ready=0`, so the write is not accepted;
  - both reads return their data;
  - 128 clear writes follow;
  - a subsequent read of addr 5 returns `INIT_VALUE`.
- `rst0_n` pulsed low during clear at `icnt=40`, and separately one cycle after a read accept → no `rsp_valid` for the lost read, and the clear restarts at `addr0=0`.
